// File: rtl/nios_debug_jtag_host.sv
// Virtual-JTAG scan host: one IR/DR scan per accepted command, TCK derived from clk.
// Optional run-test-idle phase after update is enabled by defining NIOS_DEBUG_JTAG_HOST_RTI_EN.
module nios_debug_jtag_host #(
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_ir,
  input  logic [37:0] cmd_dr,
  output logic        rsp_valid,
  output logic [37:0] rsp_dr,
  output logic        busy,
  output logic        vji_tck,
  output logic        vji_tdi,
  input  logic        vji_tdo,
  output logic [1:0]  vji_ir_in,
  output logic        vji_uir,
  output logic        vji_cdr,
  output logic        vji_sdr,
  output logic        vji_udr,
  output logic        vji_rti,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UIR   = 3'd1,
    S_CDR   = 3'd2,
    S_SHIFT = 3'd3,
    S_UDR   = 3'd4,
    S_RTI   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_cnt;
  logic        half_q;
  logic [5:0]  per_cnt;
  logic [1:0]  ir_q;
  logic [37:0] dr_q;
  logic [37:0] cap_q;
  logic [37:0] rsp_dr_q;
  logic        rsp_valid_q;

  logic accept, end_half, end_period, tck_rise;

  // Handshake: a command transfers on the clk edge where cmd_valid && cmd_ready.
  assign accept     = cmd_valid && (state_q == S_IDLE);
  assign end_half   = (div_cnt == 8'(TCK_DIV - 1));
  assign end_period = half_q && end_half;
  assign tck_rise   = !half_q && end_half;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_UIR;
      S_UIR:   if (end_period) state_d = S_CDR;
      S_CDR:   if (end_period) state_d = S_SHIFT;
      S_SHIFT: if (end_period && per_cnt == 6'd37) state_d = S_UDR;
`ifdef NIOS_DEBUG_JTAG_HOST_RTI_EN
      S_UDR:   if (end_period) state_d = S_RTI;
`else
      S_UDR:   if (end_period) state_d = S_IDLE;
`endif
      S_RTI:   if (end_period && per_cnt == 6'(RTI_CYCLES - 1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      half_q      <= 1'b0;
      per_cnt     <= '0;
      ir_q        <= '0;
      dr_q        <= '0;
      cap_q       <= '0;
      rsp_dr_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (state_q == S_IDLE) begin
        div_cnt <= '0;
        half_q  <= 1'b0;
        per_cnt <= '0;
        if (accept) begin
          ir_q <= cmd_ir;
          dr_q <= cmd_dr;
        end
      end else begin
        if (end_half) begin
          div_cnt <= '0;
          half_q  <= ~half_q;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
        if (end_period) per_cnt <= (state_d != state_q) ? 6'd0 : per_cnt + 6'd1;
        // TDO is captured on the edge that raises TCK; the capture shifts toward bit 0.
        if (tck_rise && state_q == S_SHIFT) cap_q <= {vji_tdo, cap_q[37:1]};
        if (end_period && state_q == S_SHIFT) dr_q <= {1'b0, dr_q[37:1]};
        // Response is published as a whole on IDLE re-entry, never bit by bit.
        if (state_d == S_IDLE) begin
          rsp_valid_q <= 1'b1;
          rsp_dr_q    <= cap_q;
        end
      end
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_dr    = rsp_dr_q;
  assign vji_tck   = half_q;
  assign vji_tdi   = (state_q == S_SHIFT) && dr_q[0];
  assign vji_ir_in = (state_q != S_IDLE) ? ir_q : 2'b00;
  assign vji_uir   = (state_q == S_UIR);
  assign vji_cdr   = (state_q == S_CDR);
  assign vji_sdr   = (state_q == S_SHIFT);
  assign vji_udr   = (state_q == S_UDR);
`ifdef NIOS_DEBUG_JTAG_HOST_RTI_EN
  assign vji_rti   = (state_q == S_RTI);
`else
  assign vji_rti   = 1'b0;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nios_debug_jtag_host.sv
// Bench for nios_debug_jtag_host: table-driven scans on a TCK_DIV=2 instance,
// plus back-to-back, mid-shift reset and a TCK_DIV=1 stuck-TDO instance.
module tb_nios_debug_jtag_host;

  localparam int D0  = 2;
  localparam int RTI = 4;
`ifdef NIOS_DEBUG_JTAG_HOST_RTI_EN
  localparam int P       = 41 + RTI;
  localparam int RTI_EXP = RTI;
`else
  localparam int P       = 41;
  localparam int RTI_EXP = 0;
`endif
  localparam int LAT0 = 1 + P * 2 * D0;
  localparam int LAT1 = 1 + P * 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // instance 0 (TCK_DIV=2, TDO looped back, optionally inverted)
  logic        c0_valid = 1'b0;
  logic [1:0]  c0_ir = '0;
  logic [37:0] c0_dr = '0;
  logic        inv0 = 1'b0;
  logic        r0_ready, r0_valid, r0_busy;
  logic [37:0] r0_dr;
  logic        t0_tck, t0_tdi, t0_tdo;
  logic [1:0]  ir0;
  logic        uir0, cdr0, sdr0, udr0, rti0;
  logic [2:0]  st0;
  assign t0_tdo = t0_tdi ^ inv0;

  // instance 1 (TCK_DIV=1, TDO stuck at 1)
  logic        c1_valid = 1'b0;
  logic [1:0]  c1_ir = '0;
  logic [37:0] c1_dr = '0;
  logic        r1_ready, r1_valid, r1_busy;
  logic [37:0] r1_dr;
  logic        t1_tck, t1_tdi, t1_tdo;
  logic [1:0]  ir1;
  logic        uir1, cdr1, sdr1, udr1, rti1;
  logic [2:0]  st1;
  assign t1_tdo = 1'b1;

  nios_debug_jtag_host #(.TCK_DIV(D0), .RTI_CYCLES(RTI)) u0 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(c0_valid), .cmd_ready(r0_ready),
    .cmd_ir(c0_ir), .cmd_dr(c0_dr), .rsp_valid(r0_valid), .rsp_dr(r0_dr), .busy(r0_busy),
    .vji_tck(t0_tck), .vji_tdi(t0_tdi), .vji_tdo(t0_tdo), .vji_ir_in(ir0),
    .vji_uir(uir0), .vji_cdr(cdr0), .vji_sdr(sdr0), .vji_udr(udr0), .vji_rti(rti0),
    .dbg_state(st0));

  nios_debug_jtag_host #(.TCK_DIV(1), .RTI_CYCLES(RTI)) u1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(c1_valid), .cmd_ready(r1_ready),
    .cmd_ir(c1_ir), .cmd_dr(c1_dr), .rsp_valid(r1_valid), .rsp_dr(r1_dr), .busy(r1_busy),
    .vji_tck(t1_tck), .vji_tdi(t1_tdi), .vji_tdo(t1_tdo), .vji_ir_in(ir1),
    .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1),
    .dbg_state(st1));

  int tests = 0;
  int fails = 0;
  logic [37:0] last_rsp = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_idle0(input string nm);
    check({nm, "_ready"}, 64'(r0_ready), 64'd1);
    check({nm, "_busy"}, 64'(r0_busy), 64'd0);
    check({nm, "_pins"}, 64'({t0_tck, t0_tdi, ir0}), 64'd0);
    check({nm, "_ind"}, 64'({uir0, cdr0, sdr0, udr0, rti0}), 64'd0);
  endtask

  // Counts cycles until rsp_valid; cycle 1 is the one right after the accept edge.
  task automatic wait_rsp0(output int cyc);
    cyc = 1;
    while (!r0_valid && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_scan0(input string nm, input logic [1:0] ir, input logic [37:0] dr,
                           input logic inv_v, input logic [37:0] exp);
    int cyc, pos, sdr_n, uir_n, rti_n, tdi_err, tck_err, ir_err, hold_err, busy_err;
    bit done;
    sdr_n = 0; uir_n = 0; rti_n = 0; tdi_err = 0; tck_err = 0; ir_err = 0;
    hold_err = 0; busy_err = 0; done = 0;
    @(negedge clk);
    c0_valid = 1'b1; c0_ir = ir; c0_dr = dr; inv0 = inv_v;
    check({nm, "_ready_pre"}, 64'(r0_ready), 64'd1);
    @(posedge clk); #1;
    c0_valid = 1'b0; c0_ir = ~ir; c0_dr = ~dr;
    cyc = 1;
    while (!done && cyc < 2000) begin
      if (r0_valid) done = 1;
      else begin
        pos = (cyc - 1) % (2 * D0);
        if (t0_tck !== 1'(pos >= D0)) tck_err++;
        if (ir0 !== ir) ir_err++;
        if (r0_dr !== last_rsp) hold_err++;
        if (r0_busy !== 1'b1 || r0_ready !== 1'b0) busy_err++;
        if (uir0) uir_n++;
        if (rti0) rti_n++;
        if (sdr0) begin
          if (t0_tdi !== dr[sdr_n / (2 * D0)]) tdi_err++;
          sdr_n++;
        end else if (t0_tdi !== 1'b0) tdi_err++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({nm, "_latency"}, 64'(cyc), 64'(LAT0));
    check({nm, "_rsp_dr"}, 64'(r0_dr), 64'(exp));
    check({nm, "_sdr_cycles"}, 64'(sdr_n), 64'(38 * 2 * D0));
    check({nm, "_uir_cycles"}, 64'(uir_n), 64'(2 * D0));
    check({nm, "_rti_cycles"}, 64'(rti_n), 64'(RTI_EXP * 2 * D0));
    check({nm, "_tdi_errs"}, 64'(tdi_err), 64'd0);
    check({nm, "_tck_errs"}, 64'(tck_err), 64'd0);
    check({nm, "_ir_errs"}, 64'(ir_err), 64'd0);
    check({nm, "_hold_errs"}, 64'(hold_err), 64'd0);
    check({nm, "_busy_errs"}, 64'(busy_err), 64'd0);
    check_idle0({nm, "_end"});
    last_rsp = exp;
    @(posedge clk); #1;
    check({nm, "_pulse_len"}, 64'(r0_valid), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] dr;
    logic        inv;
    logic [37:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cyc, pulses, tog_err;
    logic prev_tck;

    vecs[0] = '{2'b01, 38'h2A_5A5A_A5A5, 1'b0, 38'h2A_5A5A_A5A5};
    vecs[1] = '{2'b10, 38'h00_0000_0001, 1'b0, 38'h00_0000_0001};
    vecs[2] = '{2'b11, 38'h20_0000_0000, 1'b1, 38'h1F_FFFF_FFFF};
    vecs[3] = '{2'b00, 38'h15_5555_5555, 1'b1, 38'h2A_AAAA_AAAA};

    // reset-only
    repeat (3) @(posedge clk);
    #1;
    check_idle0("reset");
    check("reset_rsp", 64'({r0_valid, r0_dr}), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check_idle0("post_reset");

    for (int i = 0; i < 4; i++) run_scan0($sformatf("vec%0d", i), vecs[i].ir, vecs[i].dr,
                                          vecs[i].inv, vecs[i].exp);

    // back-to-back with cmd_valid held high
    @(negedge clk);
    inv0 = 1'b0; c0_valid = 1'b1; c0_ir = 2'b10; c0_dr = 38'h3C_0F0F_1234;
    @(posedge clk); #1;
    c0_ir = 2'b11; c0_dr = 38'h01_8765_4321;
    wait_rsp0(cyc);
    check("b2b_lat1", 64'(cyc), 64'(LAT0));
    check("b2b_rsp1", 64'(r0_dr), 64'h3C_0F0F_1234);
    check("b2b_ready_on_rsp", 64'(r0_ready), 64'd1);
    @(posedge clk); #1;
    c0_valid = 1'b0;
    check("b2b_uir_next", 64'(uir0), 64'd1);
    check("b2b_ir2", 64'(ir0), 64'd3);
    check("b2b_busy2", 64'(r0_busy), 64'd1);
    check("b2b_pulse", 64'(r0_valid), 64'd0);
    wait_rsp0(cyc);
    check("b2b_lat2", 64'(cyc), 64'(LAT0));
    check("b2b_rsp2", 64'(r0_dr), 64'h01_8765_4321);
    last_rsp = 38'h01_8765_4321;

    // reset during SHIFT period 20 (SHIFT starts in cycle 4*D0+1)
    @(negedge clk);
    c0_valid = 1'b1; c0_ir = 2'b01; c0_dr = 38'h2F_FFFF_0000;
    @(posedge clk); #1;
    c0_valid = 1'b0;
    cyc = 1;
    while (cyc < 4 * D0 + 20 * 2 * D0 + 2) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mid_in_shift", 64'(sdr0), 64'd1);
    reset_n = 1'b0;
    #1;
    check_idle0("mid_reset");
    check("mid_reset_rsp", 64'({r0_valid, r0_dr}), 64'd0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (r0_valid) pulses++;
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (200) begin
      @(posedge clk); #1;
      if (r0_valid) pulses++;
    end
    check("mid_no_rsp", 64'(pulses), 64'd0);
    check_idle0("mid_after");
    last_rsp = '0;
    run_scan0("after_reset", 2'b01, 38'h2A_5A5A_A5A5, 1'b0, 38'h2A_5A5A_A5A5);

    // TCK_DIV=1, TDO stuck at 1
    @(negedge clk);
    c1_valid = 1'b1; c1_ir = 2'b01; c1_dr = '0;
    @(posedge clk); #1;
    c1_valid = 1'b0;
    check("div1_first_tck", 64'(t1_tck), 64'd0);
    prev_tck = t1_tck;
    cyc = 1; tog_err = 0;
    while (!r1_valid && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (!r1_valid && t1_tck === prev_tck) tog_err++;
      prev_tck = t1_tck;
    end
    check("div1_latency", 64'(cyc), 64'(LAT1));
    check("div1_toggle_errs", 64'(tog_err), 64'd0);
    check("div1_rsp", 64'(r1_dr), 64'h3F_FFFF_FFFF);
    check("div1_idle_tck", 64'(t1_tck), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
